// File: rtl/branch_target_buffer_if.sv
// Fetch/resolve bus between the pipeline and branch_target_buffer.
// master = pipeline side (IF pc, EX resolution), slave = predictor.
interface branch_target_buffer_if #(
  parameter int ENTRIES = 32
);
  localparam int IDX = $clog2(ENTRIES);

  logic [31:0]    IF_pc;
  logic [31:0]    pc_BTB;
  logic           pred_taken;
  logic [IDX-1:0] pred_hist;

  logic           update_en;
  logic [31:0]    update_pc;
  logic [31:0]    update_target;
  logic           update_taken;
  logic           update_is_jump;
  logic [IDX-1:0] update_hist;

  modport master (
    output IF_pc, update_en, update_pc, update_target,
           update_taken, update_is_jump, update_hist,
    input  pc_BTB, pred_taken, pred_hist
  );

  modport slave (
    input  IF_pc, update_en, update_pc, update_target,
           update_taken, update_is_jump, update_hist,
    output pc_BTB, pred_taken, pred_hist
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit PHT; combinational lookup, registered training.
// Optional gshare indexing is enabled by defining GSHARE_EN.
module branch_target_buffer #(
  parameter int ENTRIES = 32
) (
  input logic                    clk,
  input logic                    reset,
  branch_target_buffer_if.slave  bus
);
  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    if (c == 2'b11) sat_inc = 2'b11;
    else            sat_inc = c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    if (c == 2'b00) sat_dec = 2'b00;
    else            sat_dec = c - 2'b01;
  endfunction

  logic [ENTRIES-1:0] valid_r;
  logic [TAGW-1:0]    tag_r    [ENTRIES];
  logic [31:0]        target_r [ENTRIES];
  logic [1:0]         pht_r    [ENTRIES];

  logic [IDX-1:0]  lk_idx_s;
  logic [TAGW-1:0] lk_tag_s;
  logic [IDX-1:0]  lk_pidx_s;
  logic            lk_hit_s;
  logic            lk_taken_s;
  logic [31:0]     lk_next_s;
  logic [IDX-1:0]  lk_hist_s;

  logic [IDX-1:0]  up_idx_s;
  logic [TAGW-1:0] up_tag_s;
  logic [IDX-1:0]  up_pidx_s;
  logic            up_hit_s;
  logic [IDX-1:0]  up_hist_s;
  logic            btb_we_s;
  logic            pht_we_s;
  logic [1:0]      pht_next_s;

`ifdef GSHARE_EN
  logic [IDX-1:0]  ghr_r;
  logic            unused_s;

  assign lk_hist_s = reset ? {IDX{1'b0}} : ghr_r;
  assign up_hist_s = bus.update_hist;
  assign unused_s  = ^{bus.IF_pc[1:0], bus.update_pc[1:0]};

  // Global history: shifts in each resolved conditional branch direction
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_r <= {IDX{1'b0}};
    end else if (bus.update_en && !bus.update_is_jump) begin
      ghr_r <= {ghr_r[IDX-2:0], bus.update_taken};
    end
  end
`else
  logic            unused_s;

  assign lk_hist_s = {IDX{1'b0}};
  assign up_hist_s = {IDX{1'b0}};
  assign unused_s  = ^{bus.IF_pc[1:0], bus.update_pc[1:0], bus.update_hist};
`endif

  // Lookup: tag compare and next-PC select; reset forces the fall-through PC
  always_comb begin
    lk_idx_s   = bus.IF_pc[IDX+1:2];
    lk_tag_s   = bus.IF_pc[31:IDX+2];
    lk_pidx_s  = lk_idx_s ^ lk_hist_s;
    lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
    lk_taken_s = lk_hit_s && pht_r[lk_pidx_s][1] && !reset;
    if (lk_taken_s) begin
      lk_next_s = target_r[lk_idx_s];
    end else begin
      lk_next_s = bus.IF_pc + 32'd4;
    end
  end

  assign bus.pc_BTB     = lk_next_s;
  assign bus.pred_taken = lk_taken_s;
  assign bus.pred_hist  = lk_hist_s;

  // Training decision: which BTB/PHT writes this resolution causes
  always_comb begin
    up_idx_s   = bus.update_pc[IDX+1:2];
    up_tag_s   = bus.update_pc[31:IDX+2];
    up_pidx_s  = up_idx_s ^ up_hist_s;
    up_hit_s   = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
    btb_we_s   = 1'b0;
    pht_we_s   = 1'b0;
    pht_next_s = pht_r[up_pidx_s];
    if (bus.update_en) begin
      pht_we_s = 1'b1;
      if (bus.update_taken && bus.update_is_jump) begin
        btb_we_s   = 1'b1;
        pht_next_s = 2'b11;
      end else if (bus.update_taken && up_hit_s) begin
        btb_we_s   = 1'b1;
        pht_next_s = sat_inc(pht_r[up_pidx_s]);
      end else if (bus.update_taken) begin
        // Allocation evicts whatever aliases into this index
        btb_we_s   = 1'b1;
        pht_next_s = 2'b10;
      end else begin
        pht_next_s = sat_dec(pht_r[up_pidx_s]);
      end
    end else begin
      btb_we_s = 1'b0;
      pht_we_s = 1'b0;
    end
  end

  // Valid bits and PHT counters: weakly-not-taken after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        pht_r[i] <= 2'b01;
      end
    end else begin
      if (btb_we_s) begin
        valid_r[up_idx_s] <= 1'b1;
      end
      if (pht_we_s) begin
        pht_r[up_pidx_s] <= pht_next_s;
      end
    end
  end

  // Tag/target payload: qualified by valid, so no reset needed
  always_ff @(posedge clk) begin
    if (btb_we_s && !reset) begin
      tag_r[up_idx_s]    <= up_tag_s;
      target_r[up_idx_s] <= bus.update_target;
    end
  end
endmodule
